// File: rtl/isl51002_pkg.sv
// Shared types and constants for the ISL51002 mode-control sequencer.
package isl51002_pkg;

    typedef enum logic [1:0] {
        NOSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mode_state_t;

    localparam int H_TOTAL_LSB      = 0;
    localparam int H_TOTAL_MSB      = 11;
    localparam int H_ACTIVE_LSB     = 12;
    localparam int H_ACTIVE_MSB     = 22;
    localparam int H_BACKPORCH_LSB  = 23;
    localparam int H_BACKPORCH_MSB  = 31;
    localparam int H_SYNCLEN_LSB    = 32;
    localparam int H_SYNCLEN_MSB    = 40;
    localparam int V_ACTIVE_LSB     = 52;
    localparam int V_ACTIVE_MSB     = 62;
    localparam int V_BACKPORCH_LSB  = 64;
    localparam int V_BACKPORCH_MSB  = 72;
    localparam int V_SYNCLEN_LSB    = 73;
    localparam int V_SYNCLEN_MSB    = 76;
    localparam int H_SKIP_LSB       = 88;
    localparam int H_SKIP_MSB       = 91;
    localparam int H_SAMPLE_SEL_LSB = 92;
    localparam int H_SAMPLE_SEL_MSB = 95;

    // Larger minus smaller, so the delta never wraps.
    function automatic logic [19:0] abs_diff(input logic [19:0] a, input logic [19:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/isl51002_meas_cmp.sv
// Frame-boundary detection and frame-to-frame measurement comparison.
module isl51002_meas_cmp
    import isl51002_pkg::*;
#(
    parameter int unsigned VTOL = 1,
    parameter int unsigned PTOL = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_change,
    input  logic [10:0] i_vtotal,
    input  logic [19:0] i_pcnt,
    input  logic        i_interlace,
    output logic        o_fb,
    output logic        o_match
);

    logic        r_fc_q;
    logic        r_fb;
    logic [10:0] r_prev_vtotal;
    logic [19:0] r_prev_pcnt;
    logic        r_prev_interlace;
    logic [19:0] w_dv;
    logic [19:0] w_dp;

    // Registered rising-edge detect; measurements are latched on every boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_q           <= 1'b0;
            r_fb             <= 1'b0;
            r_prev_vtotal    <= 11'd0;
            r_prev_pcnt      <= 20'd0;
            r_prev_interlace <= 1'b0;
        end else begin
            r_fc_q <= i_frame_change;
            r_fb   <= i_frame_change & ~r_fc_q;
            if (r_fb) begin
                r_prev_vtotal    <= i_vtotal;
                r_prev_pcnt      <= i_pcnt;
                r_prev_interlace <= i_interlace;
            end else begin
                r_prev_vtotal    <= r_prev_vtotal;
                r_prev_pcnt      <= r_prev_pcnt;
                r_prev_interlace <= r_prev_interlace;
            end
        end
    end

    assign w_dv    = abs_diff({9'd0, i_vtotal}, {9'd0, r_prev_vtotal});
    assign w_dp    = abs_diff(i_pcnt, r_prev_pcnt);
    assign o_match = (w_dv <= 20'(VTOL)) && (w_dp <= 20'(PTOL)) &&
                     (i_interlace == r_prev_interlace);
    assign o_fb    = r_fb;

endmodule

// File: rtl/isl51002_mode_ctrl.sv
// Mode lock/loss qualification and frame-synchronous config apply for the ISL51002.
// Optional sticky interrupt (irq_o / irq_clr_i) enabled by defining ISL_MODE_CTRL_IRQ_EN.
module isl51002_mode_ctrl
    import isl51002_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned VTOL          = 1,
    parameter int unsigned PTOL          = 64,
    parameter int unsigned TIMEOUT       = 2000000
) (
    input  logic        PCLK_i,
    input  logic        reset_n,
    input  logic        frame_change_i,
    input  logic [10:0] vtotal_i,
    input  logic [19:0] pcnt_frame_i,
    input  logic        interlace_i,
    input  logic [95:0] cfg_shadow_i,
    input  logic        cfg_update_req_i,
    output logic [95:0] cfg_active_o,
    output logic        cfg_update_ack_o,
    output logic        mode_locked_o,
    output logic        mode_changed_o,
    output logic        sync_lost_o,
    output logic [10:0] locked_vtotal_o,
    output logic        locked_interlace_o
`ifdef ISL_MODE_CTRL_IRQ_EN
    ,
    output logic        irq_o,
    input  logic        irq_clr_i
`endif
);

    mode_state_t r_state;
    mode_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [21:0] r_wd;
    logic        w_fb;
    logic        w_match;
    logic        w_timeout;
    logic        w_lock_evt;
    logic        w_change_evt;
    logic        w_apply;
    logic        r_armed;
    logic [95:0] r_cfg;
    logic        r_ack;
    logic        r_locked;
    logic        r_changed;
    logic        r_lost;
    logic [10:0] r_lk_vtotal;
    logic        r_lk_interlace;

    isl51002_meas_cmp #(
        .VTOL (VTOL),
        .PTOL (PTOL)
    ) u_meas_cmp (
        .clk            (PCLK_i),
        .rst_n          (reset_n),
        .i_frame_change (frame_change_i),
        .i_vtotal       (vtotal_i),
        .i_pcnt         (pcnt_frame_i),
        .i_interlace    (interlace_i),
        .o_fb           (w_fb),
        .o_match        (w_match)
    );

    // A boundary in the same cycle suppresses the timeout.
    assign w_timeout = ~w_fb & (r_wd == 22'(TIMEOUT - 1));

    // State register and match counter.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= NOSYNC;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and lock/change events.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lock_evt   = 1'b0;
        w_change_evt = 1'b0;
        case (r_state)
            NOSYNC: begin
                if (w_fb) begin
                    w_state_nxt = ACQUIRE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = NOSYNC;
                end
            end
            ACQUIRE: begin
                if (w_fb && w_match) begin
                    if (r_cnt == 4'(STABLE_FRAMES - 1)) begin
                        w_state_nxt = LOCKED;
                        w_cnt_nxt   = 4'd0;
                        w_lock_evt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else if (w_fb) begin
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            LOCKED: begin
                if (w_fb && !w_match) begin
                    w_state_nxt  = ACQUIRE;
                    w_cnt_nxt    = 4'd0;
                    w_change_evt = 1'b1;
                end else begin
                    w_state_nxt = LOCKED;
                end
            end
            default: begin
                w_state_nxt = NOSYNC;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt  = NOSYNC;
            w_cnt_nxt    = 4'd0;
            w_change_evt = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Locked mode waits for a frame boundary; unlocked applies as soon as the request is seen.
    assign w_apply = cfg_update_req_i & r_armed & ((r_state == LOCKED) ? w_fb : 1'b1);

    // Watchdog, status outputs, lock capture and config apply.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_wd           <= 22'd0;
            r_lost         <= 1'b1;
            r_locked       <= 1'b0;
            r_changed      <= 1'b0;
            r_lk_vtotal    <= 11'd0;
            r_lk_interlace <= 1'b0;
            r_armed        <= 1'b0;
            r_cfg          <= 96'd0;
            r_ack          <= 1'b0;
        end else begin
            if (w_fb) begin
                r_wd <= 22'd0;
            end else if (r_wd != 22'(TIMEOUT)) begin
                r_wd <= r_wd + 22'd1;
            end else begin
                r_wd <= r_wd;
            end

            if (w_fb) begin
                r_lost <= 1'b0;
            end else if (w_timeout) begin
                r_lost <= 1'b1;
            end else begin
                r_lost <= r_lost;
            end

            r_locked  <= (w_state_nxt == LOCKED);
            r_changed <= w_change_evt;

            if (w_lock_evt) begin
                r_lk_vtotal    <= vtotal_i;
                r_lk_interlace <= interlace_i;
            end else begin
                r_lk_vtotal    <= r_lk_vtotal;
                r_lk_interlace <= r_lk_interlace;
            end

            // Re-arm only once the request has been seen low.
            if (!cfg_update_req_i) begin
                r_armed <= 1'b1;
            end else if (w_apply) begin
                r_armed <= 1'b0;
            end else begin
                r_armed <= r_armed;
            end

            r_cfg <= w_apply ? cfg_shadow_i : r_cfg;
            r_ack <= w_apply;
        end
    end

`ifdef ISL_MODE_CTRL_IRQ_EN
    logic w_irq_set;
    logic r_irq;

    assign w_irq_set = w_change_evt | (w_timeout & ~r_lost) | w_lock_evt;

    // Sticky interrupt; a new event beats a simultaneous clear.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clr_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_irq;
        end
    end

    assign irq_o = r_irq;
`endif

    assign cfg_active_o       = r_cfg;
    assign cfg_update_ack_o   = r_ack;
    assign mode_locked_o      = r_locked;
    assign mode_changed_o     = r_changed;
    assign sync_lost_o        = r_lost;
    assign locked_vtotal_o    = r_lk_vtotal;
    assign locked_interlace_o = r_lk_interlace;

endmodule

// File: tb/tb_isl51002_mode_ctrl.sv
// Directed self-checking bench for isl51002_mode_ctrl (short watchdog timeout).
module tb_isl51002_mode_ctrl;

    localparam int unsigned TO = 300;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_change;
    logic [10:0] vtotal;
    logic [19:0] pcnt;
    logic        interlace;
    logic [95:0] shadow;
    logic        req;
    logic [95:0] cfg_active;
    logic        ack;
    logic        locked;
    logic        changed;
    logic        lost;
    logic [10:0] lk_vtotal;
    logic        lk_interlace;
`ifdef ISL_MODE_CTRL_IRQ_EN
    logic        irq;
    logic        irq_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int changed_cnt = 0;
    int ack_cnt = 0;

    localparam logic [95:0] SH1 = 96'h123456789ABCDEF012345678;
    localparam logic [95:0] SH2 = 96'hA5A5A5A5_0000FFFF_12345678;
    localparam logic [95:0] SH3 = 96'h0F0F0F0F_F0F0F0F0_CAFEBABE;
    localparam logic [95:0] SHX = 96'hDEADBEEF_DEADBEEF_DEADBEEF;

    isl51002_mode_ctrl #(
        .STABLE_FRAMES (3),
        .VTOL          (1),
        .PTOL          (64),
        .TIMEOUT       (TO)
    ) dut (
        .PCLK_i             (clk),
        .reset_n            (reset_n),
        .frame_change_i     (frame_change),
        .vtotal_i           (vtotal),
        .pcnt_frame_i       (pcnt),
        .interlace_i        (interlace),
        .cfg_shadow_i       (shadow),
        .cfg_update_req_i   (req),
        .cfg_active_o       (cfg_active),
        .cfg_update_ack_o   (ack),
        .mode_locked_o      (locked),
        .mode_changed_o     (changed),
        .sync_lost_o        (lost),
        .locked_vtotal_o    (lk_vtotal),
        .locked_interlace_o (lk_interlace)
`ifdef ISL_MODE_CTRL_IRQ_EN
        ,
        .irq_o              (irq),
        .irq_clr_i          (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output.
    always @(posedge clk) begin
        if (changed) changed_cnt <= changed_cnt + 1;
        if (ack)     ack_cnt     <= ack_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: a single-cycle frame_change high then seven low cycles.
    task automatic frame(input logic [10:0] vt, input logic [19:0] pc, input logic il);
        vtotal       = vt;
        pcnt         = pc;
        interlace    = il;
        frame_change = 1'b1;
        cycles(1);
        frame_change = 1'b0;
        cycles(7);
    endtask

    initial begin
        reset_n      = 1'b0;
        frame_change = 1'b0;
        vtotal       = 11'd0;
        pcnt         = 20'd0;
        interlace    = 1'b0;
        shadow       = 96'd0;
        req          = 1'b0;
        cycles(3);
        check_val("rst_locked", {95'd0, locked}, 96'd0);
        check_val("rst_lost", {95'd0, lost}, 96'd1);
        check_val("rst_cfg", cfg_active, 96'd0);
        check_val("rst_ack", {95'd0, ack}, 96'd0);
        check_val("rst_lkvt", {85'd0, lk_vtotal}, 96'd0);
        reset_n = 1'b1;
        cycles(2);

        // Lock at 525 lines: fourth boundary overall.
        repeat (3) frame(11'd525, 20'd450450, 1'b0);
        check_val("pre_lock", {95'd0, locked}, 96'd0);
        check_val("lost_clr", {95'd0, lost}, 96'd0);
        frame(11'd525, 20'd450450, 1'b0);
        check_val("lock525", {95'd0, locked}, 96'd1);
        check_val("lkvt525", {85'd0, lk_vtotal}, 96'd525);

        // Mode change to 625 and relock.
        frame(11'd625, 20'd450450, 1'b0);
        check_val("chg625_pulse", 96'(changed_cnt), 96'd1);
        check_val("chg625_unlk", {95'd0, locked}, 96'd0);
        repeat (2) frame(11'd625, 20'd450450, 1'b0);
        check_val("relock_early", {95'd0, locked}, 96'd0);
        frame(11'd625, 20'd450450, 1'b0);
        check_val("relock625", {95'd0, locked}, 96'd1);
        check_val("lkvt625", {85'd0, lk_vtotal}, 96'd625);

        // Tolerance boundaries.
        frame(11'd626, 20'd450514, 1'b0);
        check_val("tol_in_lock", {95'd0, locked}, 96'd1);
        check_val("tol_in_nochg", 96'(changed_cnt), 96'd1);
        frame(11'd626, 20'd450579, 1'b0);
        check_val("ptol_out_chg", 96'(changed_cnt), 96'd2);
        check_val("ptol_out_unlk", {95'd0, locked}, 96'd0);
        repeat (3) frame(11'd626, 20'd450579, 1'b0);
        check_val("relock626", {95'd0, locked}, 96'd1);

        // Interlace flip is a mode change; relock captures the flag.
        frame(11'd626, 20'd450579, 1'b1);
        check_val("il_chg", 96'(changed_cnt), 96'd3);
        repeat (3) frame(11'd626, 20'd450579, 1'b1);
        check_val("il_lock", {95'd0, locked}, 96'd1);
        check_val("il_lkflag", {95'd0, lk_interlace}, 96'd1);

        // Locked: apply waits for the boundary, held request applies once.
        shadow = SH1;
        req    = 1'b1;
        cycles(3);
        check_val("cfg_wait_fb", cfg_active, 96'd0);
        check_val("ack_wait_fb", 96'(ack_cnt), 96'd0);
        frame(11'd626, 20'd450579, 1'b1);
        check_val("cfg_apply_fb", cfg_active, SH1);
        check_val("ack_once", 96'(ack_cnt), 96'd1);
        shadow = SHX;
        repeat (2) frame(11'd626, 20'd450579, 1'b1);
        check_val("cfg_held", cfg_active, SH1);
        check_val("ack_held", 96'(ack_cnt), 96'd1);
        req = 1'b0;

        // Watchdog: no loss before TIMEOUT, loss after.
        cycles(TO - 20);
        check_val("wd_early_lost", {95'd0, lost}, 96'd0);
        check_val("wd_early_lock", {95'd0, locked}, 96'd1);
        cycles(30);
        check_val("wd_lost", {95'd0, lost}, 96'd1);
        check_val("wd_unlock", {95'd0, locked}, 96'd0);
        shadow = SH2;
        req    = 1'b1;
        cycles(2);
        check_val("nosync_apply", cfg_active, SH2);
        check_val("nosync_ack", 96'(ack_cnt), 96'd2);
        req = 1'b0;
        cycles(1);

        // Reset mid-ACQUIRE with a request pending.
        repeat (2) frame(11'd525, 20'd450450, 1'b0);
        check_val("acq_lost", {95'd0, lost}, 96'd0);
        shadow  = SH3;
        req     = 1'b1;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_cfg", cfg_active, 96'd0);
        check_val("mid_rst_lost", {95'd0, lost}, 96'd1);
        cycles(3);
        reset_n = 1'b1;
        cycles(5);
        check_val("post_rst_noack", 96'(ack_cnt), 96'd2);
        check_val("post_rst_cfg", cfg_active, 96'd0);
        req = 1'b0;
        cycles(1);
        req = 1'b1;
        cycles(2);
        check_val("new_edge_cfg", cfg_active, SH3);
        check_val("new_edge_ack", 96'(ack_cnt), 96'd3);
        req = 1'b0;
        frame(11'd525, 20'd450450, 1'b0);
        check_val("first_fb_nosync", {95'd0, locked}, 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
